// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative shift-add 32x32 multiplier that borrows the
// single-cycle ALU for its additions. One add per RUN cycle, low 32 bits of
// the product returned with a one-cycle done pulse.
//
// Optional feature: define MUL_EARLY_EXIT_EN to end RUN as soon as the
// remaining multiplier bits are all zero. The default build always runs
// 32 RUN cycles. Results are identical in both builds.
module alu_mul_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] alu_operand1,
   output logic [31:0] alu_operand2,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_NONE = 4'b0000;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [4:0]  cnt;
   logic [31:0] acc_nxt;
   logic        last;

   // Accumulator update for this RUN cycle and the end-of-RUN condition.
   // The add result is only taken when the current multiplier bit is set.
   always_comb begin
      acc_nxt = mplier[0] ? alu_out : acc;
`ifdef MUL_EARLY_EXIT_EN
      // Stop once no set multiplier bits remain after this shift.
      last = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
`else
      last = (cnt == 5'd31);
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and state-decoded outputs. ALU drive comes from
   // registers only, so start has no combinational path to any output.
   always_comb begin
      state_nxt    = state;
      busy         = 1'b0;
      done         = 1'b0;
      alu_operand1 = 32'd0;
      alu_operand2 = 32'd0;
      alu_control  = ALU_NONE;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy         = 1'b1;
            alu_operand1 = acc;
            alu_operand2 = mcand;
            alu_control  = ALU_ADD;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers: operand load on accepted start, shift-add per RUN
   // cycle, result capture on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= 32'd0;
         mcand  <= 32'd0;
         mplier <= 32'd0;
         cnt    <= 5'd0;
         result <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= 32'd0;
                  mcand  <= op_a;
                  mplier <= op_b;
                  cnt    <= 5'd0;
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
               if (last) begin
                  result <= acc_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
